// File: rtl/mmc1_serial_loader.sv
// MMC1 serial load front end: turns five one-bit CPU writes into one parallel register write.
// Define MMC1_RMW_FILTER_EN to reject writes in the cycle right after a write.
module mmc1_serial_loader #(
    parameter int unsigned SHIFT_LEN = 5,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                 CPU_M2,
    input  logic                 nRESET,
    input  logic                 nCPU_ROMSEL,
    input  logic                 nCPU_RW,
    input  logic                 CPU_A14,
    input  logic                 CPU_A13,
    input  logic                 CPU_D0,
    input  logic                 CPU_D7,
    output logic                 REG_WE,
    output logic [SEL_W-1:0]     REG_SEL,
    output logic [SHIFT_LEN-1:0] REG_DATA,
    output logic                 CTRL_RESET,
    output logic [2:0]           LOAD_CNT,
    output logic                 BUSY
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [2:0] LastCnt = 3'(SHIFT_LEN - 1);

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    // Holds only the first SHIFT_LEN-1 bits; the final bit comes straight from CPU_D0.
    logic [SHIFT_LEN-2:0]   shift_q, shift_d;
    logic                   reg_we_q, reg_we_d;
    logic [SEL_W-1:0]       reg_sel_q, reg_sel_d;
    logic [SHIFT_LEN-1:0]   reg_data_q, reg_data_d;
    logic                   ctrl_reset_q, ctrl_reset_d;

    logic hit;
    logic accept;

    assign hit = !nCPU_ROMSEL && !nCPU_RW;

`ifdef MMC1_RMW_FILTER_EN
    logic prev_hit_q;

    // Tracks every hit, accepted or not, so an RMW double write only counts once.
    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            prev_hit_q <= 1'b0;
        end else begin
            prev_hit_q <= hit;
        end
    end

    assign accept = hit && !prev_hit_q;
`else
    assign accept = hit;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        reg_we_d     = 1'b0;
        ctrl_reset_d = 1'b0;
        reg_sel_d    = reg_sel_q;
        reg_data_d   = reg_data_q;

        if (accept) begin
            if (CPU_D7) begin
                state_d      = StIdle;
                cnt_d        = 3'd0;
                shift_d      = '0;
                ctrl_reset_d = 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        shift_d = {CPU_D0, shift_q[SHIFT_LEN-2:1]};
                        cnt_d   = 3'd1;
                        state_d = StShift;
                    end
                    StShift: begin
                        if (cnt_q == LastCnt) begin
                            reg_data_d = {CPU_D0, shift_q};
                            reg_sel_d  = SEL_W'({CPU_A14, CPU_A13});
                            reg_we_d   = 1'b1;
                            shift_d    = '0;
                            cnt_d      = 3'd0;
                            state_d    = StIdle;
                        end else begin
                            shift_d = {CPU_D0, shift_q[SHIFT_LEN-2:1]};
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                        shift_d = '0;
                    end
                endcase
            end
        end
    end

    // Data is valid at the end of the CPU cycle, so everything updates on the M2 falling edge.
    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            shift_q      <= '0;
            reg_we_q     <= 1'b0;
            reg_sel_q    <= '0;
            reg_data_q   <= '0;
            ctrl_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            reg_we_q     <= reg_we_d;
            reg_sel_q    <= reg_sel_d;
            reg_data_q   <= reg_data_d;
            ctrl_reset_q <= ctrl_reset_d;
        end
    end

    assign REG_WE     = reg_we_q;
    assign REG_SEL    = reg_sel_q;
    assign REG_DATA   = reg_data_q;
    assign CTRL_RESET = ctrl_reset_q;
    assign LOAD_CNT   = cnt_q;
    assign BUSY       = (cnt_q != 3'd0);

endmodule
